// File: rtl/count_bcd_seg7_if.sv
// Display-stage bus: counter value and strobe in, 7-segment drive and BCD result out.
interface count_bcd_seg7_if;
    logic [7:0]  Count;
    logic        CLK_200KHz;
    logic [7:0]  SEG;
    logic [2:0]  DIG;
    logic [11:0] BCD;
    logic        Valid;

    modport master (
        output Count,
        output CLK_200KHz,
        input  SEG,
        input  DIG,
        input  BCD,
        input  Valid
    );

    modport slave (
        input  Count,
        input  CLK_200KHz,
        output SEG,
        output DIG,
        output BCD,
        output Valid
    );
endinterface

// File: rtl/count_bcd_seg7.sv
// Binary-to-BCD (sequential double dabble) plus 3-digit multiplexed 7-segment driver.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module count_bcd_seg7 #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input logic             CLK_50MHz,
    input logic             Res,
    count_bcd_seg7_if.slave bus
);

    localparam int unsigned CntW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [7:0]  SegOff = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [2:0]  DigOff = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [2:0] {StIdle, StLoad, StAdj, StShf, StDone} state_e;

    state_e         state_q;
    logic [2:0]     sync_q;
    logic [7:0]     shift_q;
    logic [11:0]    scratch_q;
    logic [2:0]     bit_cnt_q;
    logic [11:0]    bcd_q;
    logic           valid_q;
    logic [CntW-1:0] scan_cnt_q;
    logic [1:0]     digit_q;
    logic [7:0]     seg_q;
    logic [2:0]     dig_q;
    logic           start;

    // The strobe is asynchronous data here: two flops to settle, a third to find the edge.
    assign start = sync_q[1] & ~sync_q[2];

    always_ff @(posedge CLK_50MHz or negedge Res) begin
        if (!Res) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], bus.CLK_200KHz};
        end
    end

    always_ff @(posedge CLK_50MHz or negedge Res) begin
        if (!Res) begin
            state_q   <= StIdle;
            shift_q   <= 8'h00;
            scratch_q <= 12'h000;
            bit_cnt_q <= 3'd0;
            bcd_q     <= 12'h000;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) state_q <= StLoad;
                end
                StLoad: begin
                    shift_q   <= bus.Count;
                    scratch_q <= 12'h000;
                    bit_cnt_q <= 3'd0;
                    state_q   <= StAdj;
                end
                StAdj: begin
                    for (int i = 0; i < 3; i++) begin
                        if (scratch_q[4*i +: 4] >= 4'd5) begin
                            scratch_q[4*i +: 4] <= scratch_q[4*i +: 4] + 4'd3;
                        end
                    end
                    state_q <= StShf;
                end
                StShf: begin
                    {scratch_q, shift_q} <= {scratch_q[10:0], shift_q, 1'b0};
                    bit_cnt_q            <= bit_cnt_q + 3'd1;
                    state_q              <= (bit_cnt_q == 3'd7) ? StDone : StAdj;
                end
                StDone: begin
                    bcd_q   <= scratch_q;
                    valid_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_50MHz or negedge Res) begin
        if (!Res) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
        end else if (scan_cnt_q == CntW'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            digit_q    <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + CntW'(1);
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [3:0] nibble;
    logic       blank;
    logic [7:0] seg_next;
    logic [2:0] dig_next;

    always_comb begin
        nibble   = 4'h0;
        dig_next = DigOff;
        unique case (digit_q)
            2'd0: begin nibble = bcd_q[3:0];  dig_next = 3'b001 ^ DigOff; end
            2'd1: begin nibble = bcd_q[7:4];  dig_next = 3'b010 ^ DigOff; end
            2'd2: begin nibble = bcd_q[11:8]; dig_next = 3'b100 ^ DigOff; end
            default: ;
        endcase
`ifdef SEG7_LZB_EN
        blank = ((digit_q == 2'd2) && (bcd_q[11:8] == 4'h0)) ||
                ((digit_q == 2'd1) && (bcd_q[11:4] == 8'h00));
`else
        blank = 1'b0;
`endif
        seg_next = blank ? SegOff : ({1'b0, seg_decode(nibble)} ^ SegOff);
    end

    always_ff @(posedge CLK_50MHz or negedge Res) begin
        if (!Res) begin
            seg_q <= SegOff;
            dig_q <= DigOff;
        end else begin
            seg_q <= seg_next;
            dig_q <= dig_next;
        end
    end

    assign bus.SEG   = seg_q;
    assign bus.DIG   = dig_q;
    assign bus.BCD   = bcd_q;
    assign bus.Valid = valid_q;

endmodule

// File: tb/tb_count_bcd_seg7.sv
// Self-checking bench for count_bcd_seg7: randomized conversions against a /100,/10 model,
// busy/reset behaviour and display scan checks with a short scan period.
module tb_count_bcd_seg7;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   checks = 0;
    int   failures = 0;

    count_bcd_seg7_if bus_if ();

    count_bcd_seg7 #(
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK_50MHz (clk),
        .Res       (res),
        .bus       (bus_if)
    );

    always #10 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Expected active-low SEG for the digit d (0 ones, 1 tens, 2 hundreds) of value v.
    function automatic logic [7:0] ref_seg(input int v, input int d);
        int digit;
        bit blank;
        digit = (d == 0) ? v % 10 : (d == 1) ? (v / 10) % 10 : v / 100;
        blank = 1'b0;
`ifdef SEG7_LZB_EN
        blank = ((d == 2) && (v < 100)) || ((d == 1) && (v < 10));
`endif
        return blank ? 8'hFF : ~{1'b0, seg_tab[digit]};
    endfunction

    function automatic int dig_to_idx(input logic [2:0] dig);
        case (dig)
            3'b110:  return 0;
            3'b101:  return 1;
            3'b011:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic convert(input int v);
        int n;
        bit got;
        @(negedge clk);
        bus_if.Count      = 8'(v);
        bus_if.CLK_200KHz = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 3) bus_if.CLK_200KHz = 1'b0;
            if (n == 5) bus_if.Count = 8'($urandom);
            if (bus_if.Valid) got = 1'b1;
        end
        bus_if.CLK_200KHz = 1'b0;
        check("conv_latency", n, 21);
        check("conv_bcd", bus_if.BCD, ref_bcd(v));
        @(negedge clk);
        check("valid_one_cycle", bus_if.Valid, 1'b0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic scan_check(input int v, input int ncyc);
        int prev, d, run;
        bit seen_change;
        prev        = -1;
        run         = 0;
        seen_change = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            d = dig_to_idx(bus_if.DIG);
            check("scan_dig_onehot", 32'(d >= 0), 1);
            if (d >= 0) begin
                check("scan_seg", bus_if.SEG, ref_seg(v, d));
                if (prev >= 0 && d != prev) begin
                    check("scan_order", d, (prev + 1) % 3);
                    if (seen_change) check("scan_period", run, 4);
                    seen_change = 1'b1;
                    run = 1;
                end else begin
                    run++;
                end
                prev = d;
            end
        end
    endtask

    initial begin
        int order [256];
        int valids;
        logic [11:0] seen_bcd;

        bus_if.Count      = 8'h00;
        bus_if.CLK_200KHz = 1'b0;

        // Reset and idle behaviour
        #200;
        @(negedge clk);
        res = 1'b1;
        #1;
        check("rst_seg", bus_if.SEG, 8'hFF);
        check("rst_dig", bus_if.DIG, 3'b111);
        check("rst_bcd", bus_if.BCD, 12'h000);
        check("rst_valid", bus_if.Valid, 1'b0);
        valids = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus_if.Valid) valids++;
        end
        check("idle_no_valid", valids, 0);

        // Directed conversions
        convert(0);
        convert(128);
        convert(255);

        // Busy: second strobe edge 8 cycles after the first is ignored
        @(negedge clk);
        bus_if.Count      = 8'd37;
        bus_if.CLK_200KHz = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.CLK_200KHz = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.Count      = 8'd99;
        bus_if.CLK_200KHz = 1'b1;
        valids   = 0;
        seen_bcd = 12'hFFF;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 3) bus_if.CLK_200KHz = 1'b0;
            if (bus_if.Valid) begin
                valids++;
                seen_bcd = bus_if.BCD;
            end
        end
        check("busy_valid_count", valids, 1);
        check("busy_bcd", seen_bcd, 12'h037);

        // Reset mid-conversion
        res = 1'b0;
        #1;
        res = 1'b1;
        @(negedge clk);
        bus_if.Count      = 8'd50;
        bus_if.CLK_200KHz = 1'b1;
        repeat (10) @(negedge clk);
        res               = 1'b0;
        bus_if.CLK_200KHz = 1'b0;
        #1;
        check("midrst_valid", bus_if.Valid, 1'b0);
        check("midrst_seg", bus_if.SEG, 8'hFF);
        check("midrst_dig", bus_if.DIG, 3'b111);
        repeat (3) @(negedge clk);
        res    = 1'b1;
        valids = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus_if.Valid) valids++;
        end
        check("midrst_no_valid", valids, 0);
        check("midrst_bcd", bus_if.BCD, 12'h000);
        convert(42);

        // Exhaustive sweep in shuffled order
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j        = $urandom_range(0, i);
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) convert(order[i]);

        // Display scan
        convert(255);
        scan_check(255, 30);
        convert(7);
        scan_check(7, 30);
        convert(int'($urandom_range(0, 255)));
        scan_check(int'(bus_if.BCD[11:8]) * 100 + int'(bus_if.BCD[7:4]) * 10 +
                   int'(bus_if.BCD[3:0]), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_bcd_seg7.md
Name: count_bcd_seg7

Overview:
- Downstream display stage for the 8-bit LED counter.
- Consumes the counter's 8-bit value and its 200 kHz strobe clock.
- Converts the value to 3-digit BCD with a sequential double-dabble FSM, then drives a time-multiplexed 3-digit 7-segment display.
- Runs entirely in the 50 MHz domain; the 200 kHz input is treated as data and edge-detected.

Parameters:
SCAN_DIV, 50000, CLK_50MHz cycles per digit slot (1 kHz per digit); legal values ≥ 2.
SEG_ACTIVE_LOW, 1, 1 = segment and digit outputs active-low (common anode); 0 = active-high.

Ports:
CLK_50MHz  input  1  system clock, rising-edge.
Res  input  1  asynchronous, active-low reset.
Count  input  8  binary value from the counter.
CLK_200KHz  input  1  counter's strobe clock; each rising edge requests a conversion.
SEG  output  8  bit0..6 = segments a..g, bit7 = dp; dp is always off.
DIG  output  3  digit enables: DIG[0] ones, DIG[1] tens, DIG[2] hundreds.
BCD  output  12  latched result: [11:8] hundreds, [7:4] tens, [3:0] ones.
Valid  output  1  one-cycle pulse when BCD updates.

Behaviour:
- Reset (Res low, asynchronous):
  - FSM returns to IDLE; BCD = 0; Valid = 0.
  - Scan counter = 0; digit index = 0; sync flops cleared.
  - SEG and DIG at inactive level (all 1 when SEG_ACTIVE_LOW = 1).
- Tick detect:
  - CLK_200KHz passes through a 2-flop synchronizer plus a delay flop.
  - start = sync2 & ~sync3.
- FSM states:
  - IDLE: on start, go to LOAD; otherwise stay.
  - LOAD (1 cycle): capture Count into shift register; clear the 12-bit scratch BCD; bit counter = 0.
  - ADJ (1 cycle): each scratch nibble ≥ 5 gets +3. Nibbles are adjusted independently; values ≤ 15 never overflow a nibble.
  - SHF (1 cycle): shift {scratch, shift register} left by 1; bit counter +1. If bit counter was 7, go to DONE; else go to ADJ.
  - DONE (1 cycle): BCD ← scratch; Valid = 1 for this cycle only; go to IDLE.
- Latency:
  - Conversion is fixed at 18 cycles: LOAD + 8×(ADJ+SHF) + DONE.
  - From the first clock edge sampling CLK_200KHz high to the Valid pulse is 21 cycles.
  - Max Count 255 → BCD 0x255; no overflow possible.
- start while not IDLE:
  - Ignored, and not queued.
  - Count is sampled only in LOAD, so Count changing mid-conversion has no effect.
- Reset mid-conversion: aborts the conversion; BCD stays 0 until the next complete conversion.
- Scan:
  - Free-running counter 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→0.
  - Exactly one DIG bit is active at a time, selected by the index.
  - SEG shows the decoded nibble of the latched BCD for that digit.
  - SEG and DIG are registered, so they change one cycle after the index changes.
- Decode, active-high a..g before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A–F are unreachable; they decode to blank.
  - Polarity inversion is applied when SEG_ACTIVE_LOW = 1.
- BCD update while a digit is displayed: the new value appears on SEG in the next cycle; no digit-slot alignment.

Optional Feature:
SEG7_LZB_EN (leading-zero blanking):
- Defined:
  - Hundreds digit blanked (SEG inactive, DIG still scanned) when the hundreds nibble = 0.
  - Tens digit blanked when hundreds = 0 and tens = 0.
  - Ones digit is never blanked.
- Undefined: all three digits always show their value, including leading zeros (7 shows "007").

Test Plan:
- Reset: hold Res low for 200 ns, then release → SEG = 8'hFF, DIG = 3'b111, BCD = 0, Valid = 0; no Valid until the first CLK_200KHz edge.
- Conversion: Count = 0 with one tick → Valid after 21 cycles, BCD = 12'h000. Repeat with Count = 128 → 12'h128 and Count = 255 → 12'h255. Exhaustive sweep 0..255 checked against a reference /100, /10 model.
- Busy: second CLK_200KHz rising edge 8 cycles after the first, with Count changed from 37 to 99 → exactly one Valid; BCD = 12'h037.
- Reset mid-conversion: assert Res 10 cycles after start → no Valid; BCD = 0. A subsequent tick with Count = 42 → BCD = 12'h042.
- Scan (SCAN_DIV = 4, BCD = 0x255, active-low):
  - DIG cycles 110 → 101 → 011 with a period of 4 cycles per digit.
  - SEG = ~6D for ones and tens, ~5B for hundreds.
- Blanking (SEG7_LZB_EN defined, Count = 7) → hundreds and tens slots show SEG = 8'hFF; ones slot shows ~07 = 8'hF8. Without the macro, the hundreds and tens slots show ~3F = 8'hC0.
